// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: round-robin ALU/MEM/LINK grant, registered write
// port and a pending-write scoreboard that raises Stall on read-after-write hazards.
module regwrite_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AluReq,
  input  logic [4:0]        AluReg,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluGnt,
  input  logic              MemReq,
  input  logic [4:0]        MemReg,
  input  logic [DATA_W-1:0] MemData,
  output logic              MemGnt,
  input  logic              LinkReq,
  input  logic [DATA_W-1:0] LinkAddr,
  output logic              LinkGnt,
  input  logic              IssueValid,
  input  logic [4:0]        IssueReg,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic              Stall,
  output logic              RegWrite,
  output logic [4:0]        WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       PendingMask
);

  localparam logic [1:0] PTR_ALU  = 2'd0;
  localparam logic [1:0] PTR_MEM  = 2'd1;
  localparam logic [1:0] PTR_LINK = 2'd2;

  // Handshake: a requester holds Req/Reg/Data until its Gnt is high in the same
  // cycle; that single-cycle Gnt consumes exactly one request.
  logic [1:0]        ptr;
  logic [1:0]        nextPtr;
  logic [2:0]        gntVec;   // bit 0 ALU, bit 1 MEM, bit 2 LINK
  logic              anyGnt;
  logic [4:0]        selReg;
  logic [DATA_W-1:0] selData;
  logic [31:0]       clrMask;
  logic [31:0]       setMask;
  logic [31:0]       maskNext;

  always_comb begin
    gntVec = 3'b000;
    if (!Reset) begin
      case (ptr)
        PTR_MEM: begin
          if (MemReq)       gntVec = 3'b010;
          else if (LinkReq) gntVec = 3'b100;
          else if (AluReq)  gntVec = 3'b001;
        end
        PTR_LINK: begin
          if (LinkReq)      gntVec = 3'b100;
          else if (AluReq)  gntVec = 3'b001;
          else if (MemReq)  gntVec = 3'b010;
        end
        default: begin
          if (AluReq)       gntVec = 3'b001;
          else if (MemReq)  gntVec = 3'b010;
          else if (LinkReq) gntVec = 3'b100;
        end
      endcase
    end
  end

  assign AluGnt  = gntVec[0];
  assign MemGnt  = gntVec[1];
  assign LinkGnt = gntVec[2];
  assign anyGnt  = |gntVec;

  always_comb begin
    selReg  = AluReg;
    selData = AluData;
    nextPtr = ptr;
    if (gntVec[0]) begin
      nextPtr = PTR_MEM;
    end else if (gntVec[1]) begin
      selReg  = MemReg;
      selData = MemData;
      nextPtr = PTR_LINK;
    end else if (gntVec[2]) begin
      // jal writes the return address into $ra
      selReg  = 5'd31;
      selData = LinkAddr + DATA_W'(1);
      nextPtr = PTR_ALU;
    end
  end

  // A set from issue overrides a clear from the write retiring in this cycle.
  always_comb begin
    clrMask  = RegWrite ? (32'd1 << WriteReg) : 32'd0;
    setMask  = (IssueValid && IssueReg != 5'd0) ? (32'd1 << IssueReg) : 32'd0;
    maskNext = ((PendingMask & ~clrMask) | setMask) & ~32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr         <= PTR_ALU;
      RegWrite    <= 1'b0;
      WriteReg    <= 5'd0;
      WriteData   <= '0;
      PendingMask <= 32'd0;
    end else begin
      ptr         <= nextPtr;
      RegWrite    <= anyGnt && (selReg != 5'd0);
      PendingMask <= maskNext;
      if (anyGnt && selReg != 5'd0) begin
        WriteReg  <= selReg;
        WriteData <= selData;
      end
    end
  end

  assign Stall = (ReadReg1 != 5'd0 && PendingMask[ReadReg1]) ||
                 (ReadReg2 != 5'd0 && PendingMask[ReadReg2]);

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_regwrite_arbiter;

  localparam int DATA_W = 32;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              AluReq, MemReq, LinkReq, IssueValid;
  logic [4:0]        AluReg, MemReg, IssueReg, ReadReg1, ReadReg2;
  logic [DATA_W-1:0] AluData, MemData, LinkAddr;
  logic              AluGnt, MemGnt, LinkGnt, Stall, RegWrite;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [31:0]       PendingMask;

  regwrite_arbiter #(.DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluReq(AluReq), .AluReg(AluReg), .AluData(AluData), .AluGnt(AluGnt),
    .MemReq(MemReq), .MemReg(MemReg), .MemData(MemData), .MemGnt(MemGnt),
    .LinkReq(LinkReq), .LinkAddr(LinkAddr), .LinkGnt(LinkGnt),
    .IssueValid(IssueValid), .IssueReg(IssueReg),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .Stall(Stall),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .PendingMask(PendingMask)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: requester index 0=ALU 1=MEM 2=LINK
  int              m_ptr = 0;
  bit              m_pend[32];
  bit              m_we = 0;
  logic [4:0]      m_wreg = 0;
  logic [31:0]     m_wdata = 0;
  int              last_g = -1;

  always begin
    @(negedge Clk);
    if (chk_en) begin
      bit          req[3];
      int          g;
      logic [31:0] exp_mask;
      bit          exp_stall;
      bit          n_pend[32];
      req[0] = AluReq; req[1] = MemReq; req[2] = LinkReq;
      g = -1;
      if (!Reset)
        for (int k = 0; k < 3; k++)
          if (g < 0 && req[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      exp_mask = 0;
      for (int i = 0; i < 32; i++) exp_mask[i] = m_pend[i];
      exp_stall = (ReadReg1 != 0 && m_pend[ReadReg1]) || (ReadReg2 != 0 && m_pend[ReadReg2]);
      check("alu_gnt", AluGnt, g == 0);
      check("mem_gnt", MemGnt, g == 1);
      check("link_gnt", LinkGnt, g == 2);
      check("stall", Stall, exp_stall);
      check("reg_write", RegWrite, m_we);
      check("write_reg", WriteReg, m_wreg);
      check("write_data", WriteData, m_wdata);
      check("pending_mask", PendingMask, exp_mask);
      last_g = g;
      for (int i = 0; i < 32; i++) begin
        n_pend[i] = m_pend[i];
        if (m_we && m_wreg == i) n_pend[i] = 0;
        if (IssueValid && IssueReg == i && i != 0) n_pend[i] = 1;
      end
      @(posedge Clk);
      if (Reset) begin
        m_ptr = 0; m_we = 0; m_wreg = 0; m_wdata = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else begin
        m_pend = n_pend;
        m_we = 0;
        if (g >= 0) begin
          logic [4:0]  r;
          logic [31:0] d;
          m_ptr = (g + 1) % 3;
          r = (g == 0) ? AluReg : (g == 1) ? MemReg : 5'd31;
          d = (g == 0) ? AluData : (g == 1) ? MemData : LinkAddr + 32'd1;
          if (r != 0) begin
            m_we = 1; m_wreg = r; m_wdata = d;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    Reset = 1; AluReq = 0; MemReq = 0; LinkReq = 0; IssueValid = 0;
    cyc();
    Reset = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    Reset = 1; AluReq = 0; MemReq = 0; LinkReq = 0; IssueValid = 0;
    AluReg = 0; MemReg = 0; IssueReg = 0; ReadReg1 = 0; ReadReg2 = 0;
    AluData = 0; MemData = 0; LinkAddr = 0;
    @(posedge Clk);
    #1 chk_en = 1;
    cyc();
    Reset = 0;
    @(negedge Clk);
    check("rst_regwrite", RegWrite, 0);
    check("rst_mask", PendingMask, 0);
    check("rst_wreg", WriteReg, 0);
    check("rst_wdata", WriteData, 0);

    // single ALU write
    cyc(); AluReq = 1; AluReg = 5; AluData = 32'h1234;
    @(negedge Clk); check("alu1_gnt", AluGnt, 1);
    cyc(); AluReq = 0;
    @(negedge Clk);
    check("alu1_we", RegWrite, 1);
    check("alu1_reg", WriteReg, 5);
    check("alu1_data", WriteData, 32'h1234);
    cyc();
    @(negedge Clk);
    check("hold_we", RegWrite, 0);
    check("hold_reg", WriteReg, 5);

    // round-robin from reset
    do_reset();
    cyc();
    AluReq = 1; AluReg = 1; MemReq = 1; MemReg = 2; LinkReq = 1; LinkAddr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("rr_gnt", {29'd0, LinkGnt, MemGnt, AluGnt}, 32'd1 << (i % 3));
      if (i < 3) cyc();
    end
    cyc(); AluReq = 0; MemReq = 0; LinkReq = 0;

    // link wrap and increment
    cyc(); LinkReq = 1; LinkAddr = 32'hFFFF_FFFF;
    @(negedge Clk); check("link_gnt_a", LinkGnt, 1);
    cyc(); LinkReq = 0;
    @(negedge Clk);
    check("link_reg", WriteReg, 31);
    check("link_wrap", WriteData, 32'h0);
    cyc(); LinkReq = 1; LinkAddr = 32'h40;
    cyc(); LinkReq = 0;
    @(negedge Clk); check("link_inc", WriteData, 32'h41);

    // scoreboard hazard on reg 7
    do_reset();
    cyc(); IssueValid = 1; IssueReg = 7; ReadReg1 = 7;
    @(negedge Clk); check("sb_pre", Stall, 0);
    cyc(); IssueValid = 0;
    @(negedge Clk); check("sb_set", Stall, 1);
    cyc(); MemReq = 1; MemReg = 7; MemData = 32'hBEEF;
    @(negedge Clk); check("sb_mgnt", MemGnt, 1); check("sb_stall_g", Stall, 1);
    cyc(); MemReq = 0;
    @(negedge Clk); check("sb_wr", RegWrite, 1); check("sb_stall_w", Stall, 1);
    cyc();
    @(negedge Clk); check("sb_clr", Stall, 0);
    cyc(); IssueValid = 1; IssueReg = 7;
    cyc(); IssueValid = 0; MemReq = 1;
    cyc(); MemReq = 0; IssueValid = 1; IssueReg = 7;
    @(negedge Clk); check("sb_wr2", RegWrite, 1);
    cyc(); IssueValid = 0;
    @(negedge Clk); check("sb_setwins", Stall, 1); check("sb_bit7", PendingMask[7], 1);

    // register 0
    cyc(); AluReq = 1; AluReg = 0; AluData = 32'h55; ReadReg1 = 0;
    @(negedge Clk); check("r0_gnt", AluGnt, 1);
    cyc(); AluReq = 0; IssueValid = 1; IssueReg = 0;
    @(negedge Clk); check("r0_nowe", RegWrite, 0);
    cyc(); IssueValid = 0;
    @(negedge Clk); check("r0_stall", Stall, 0); check("r0_bit0", PendingMask[0], 0);

    // reset while MEM is the candidate
    cyc(); IssueValid = 1; IssueReg = 9;
    cyc(); IssueValid = 0; MemReq = 1; MemReg = 9; MemData = 32'h1; Reset = 1;
    @(negedge Clk); check("rst_nognt", MemGnt, 0);
    cyc(); Reset = 0; AluReq = 1; AluReg = 3; LinkReq = 1;
    @(negedge Clk);
    check("rst_we", RegWrite, 0);
    check("rst_mask2", PendingMask, 0);
    check("rst_ptr", AluGnt, 1);
    cyc(); AluReq = 0; MemReq = 0; LinkReq = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (last_g == 0) AluReq = 0;
      if (last_g == 1) MemReq = 0;
      if (last_g == 2) LinkReq = 0;
      if (!AluReq && $urandom_range(0, 2) == 0) begin
        AluReq = 1; AluReg = pick_reg(); AluData = $urandom;
      end
      if (!MemReq && $urandom_range(0, 2) == 0) begin
        MemReq = 1; MemReg = pick_reg(); MemData = $urandom;
      end
      if (!LinkReq && $urandom_range(0, 5) == 0) begin
        LinkReq = 1;
        LinkAddr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      IssueValid = 1'($urandom_range(0, 1));
      IssueReg = pick_reg();
      ReadReg1 = pick_reg();
      ReadReg2 = pick_reg();
      Reset = ($urandom_range(0, 199) == 0);
    end
    cyc();
    Reset = 0; AluReq = 0; MemReq = 0; LinkReq = 0; IssueValid = 0;
    repeat (3) @(posedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
